// File: rtl/datapath_sequencer_if.sv
// Control bus between the instruction decoder, datapath_sequencer and the register-file/ALU datapath.
interface datapath_sequencer_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [1:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       w;
    logic       err;

    // Decoder side: issues instructions, observes the datapath strobes.
    modport master (
        output s, opcode, op,
        input  nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, w, err
    );

    // Sequencer side.
    modport slave (
        input  s, opcode, op,
        output nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, w, err
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Moore controller that steps the register-file/ALU datapath through one decoded instruction.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN (illegal class halts with err=1 instead of acting as a NOP).
module datapath_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    datapath_sequencer_if.slave  bus
);
    localparam int unsigned CLS_W = 5;

    localparam logic [CLS_W-1:0] CLS_MOV_IMM = 5'b110_10;
    localparam logic [CLS_W-1:0] CLS_MOV_REG = 5'b110_00;
    localparam logic [CLS_W-1:0] CLS_ADD     = 5'b101_00;
    localparam logic [CLS_W-1:0] CLS_CMP     = 5'b101_01;
    localparam logic [CLS_W-1:0] CLS_AND     = 5'b101_10;
    localparam logic [CLS_W-1:0] CLS_MVN     = 5'b101_11;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_ALU       = 3'd5,
        ST_WRITE_REG = 3'd6
`ifdef SEQ_ILLEGAL_TRAP_EN
        , ST_HALT    = 3'd7
`endif
    } state_t;

    typedef struct packed {
        logic [1:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
        logic       w;
        logic       err;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{nsel: 2'b00, vsel: 2'b00, w: 1'b1, default: 1'b0};

    state_t           state_q, state_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    ctrl_t            ctrl_q, ctrl_d;

    // State, latched class and registered strobes (decoded from the state being entered).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT;
            cls_q   <= '0;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        ctrl_d  = '0;

        case (state_q)
            ST_WAIT: begin
                if (bus.s) begin
                    state_d = ST_DECODE;
                    cls_d   = {bus.opcode, bus.op};
                end
            end
            ST_DECODE: begin
                case (cls_q)
                    CLS_MOV_IMM:                state_d = ST_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:       state_d = ST_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:  state_d = ST_GET_A;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    default:                    state_d = ST_HALT;
`else
                    default:                    state_d = ST_WAIT;
`endif
                endcase
            end
            ST_WRITE_IMM: state_d = ST_WAIT;
            ST_GET_A:     state_d = ST_GET_B;
            ST_GET_B:     state_d = ST_ALU;
            ST_ALU:       state_d = (cls_q == CLS_CMP) ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_d = ST_WAIT;
`ifdef SEQ_ILLEGAL_TRAP_EN
            ST_HALT:      state_d = ST_HALT;
`endif
            default:      state_d = ST_WAIT;
        endcase

        // Outputs follow the state being entered, so they are registered yet still Moore.
        case (state_d)
            ST_WAIT: ctrl_d.w = 1'b1;
            ST_WRITE_IMM: begin
                ctrl_d.nsel  = 2'b00;
                ctrl_d.vsel  = 2'b10;
                ctrl_d.write = 1'b1;
            end
            ST_GET_A: begin
                ctrl_d.nsel  = 2'b00;
                ctrl_d.loada = 1'b1;
            end
            ST_GET_B: begin
                ctrl_d.nsel  = 2'b10;
                ctrl_d.loadb = 1'b1;
            end
            ST_ALU: begin
                ctrl_d.asel = (cls_d == CLS_MOV_REG);
                if (cls_d == CLS_CMP) ctrl_d.loads = 1'b1;
                else                  ctrl_d.loadc = 1'b1;
            end
            ST_WRITE_REG: begin
                ctrl_d.nsel  = 2'b01;
                ctrl_d.vsel  = 2'b00;
                ctrl_d.write = 1'b1;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            ST_HALT: ctrl_d.err = 1'b1;
`endif
            default: ctrl_d = '0;
        endcase
    end

    assign bus.nsel  = ctrl_q.nsel;
    assign bus.loada = ctrl_q.loada;
    assign bus.loadb = ctrl_q.loadb;
    assign bus.loadc = ctrl_q.loadc;
    assign bus.loads = ctrl_q.loads;
    assign bus.asel  = ctrl_q.asel;
    assign bus.bsel  = ctrl_q.bsel;
    assign bus.vsel  = ctrl_q.vsel;
    assign bus.write = ctrl_q.write;
    assign bus.w     = ctrl_q.w;
    assign bus.err   = ctrl_q.err;
endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: per-cycle expected strobe vectors are queued at issue and compared as the sequence runs.
module tb_datapath_sequencer;
    logic clk;
    logic reset;

    datapath_sequencer_if bus ();

    datapath_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [12:0] sb[$];

    // {nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, w, err}
    function automatic logic [12:0] vec(input logic [1:0] nsel, input logic la, input logic lb,
                                        input logic lc, input logic ls, input logic as,
                                        input logic bs, input logic [1:0] vs, input logic wr,
                                        input logic w, input logic er);
        return {nsel, la, lb, lc, ls, as, bs, vs, wr, w, er};
    endfunction

    function automatic logic [12:0] obs();
        return {bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
                bus.bsel, bus.vsel, bus.write, bus.w, bus.err};
    endfunction

    logic [12:0] v_idle, v_dec, v_wimm, v_geta, v_getb, v_alu_c, v_alu_mov, v_alu_s, v_wreg, v_halt;

    initial begin
        v_idle    = vec(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        v_dec     = vec(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        v_wimm    = vec(2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0);
        v_geta    = vec(2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        v_getb    = vec(2'b10, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        v_alu_c   = vec(2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        v_alu_mov = vec(2'b00, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0);
        v_alu_s   = vec(2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        v_wreg    = vec(2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        v_halt    = vec(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    end

    // Expected output vector for every cycle after the s-sampling edge, up to the return to WAIT.
    task automatic push_expected(input logic [4:0] cls);
        sb.push_back(v_dec);
        case (cls)
            5'b110_10: begin sb.push_back(v_wimm); end
            5'b110_00: begin sb.push_back(v_getb); sb.push_back(v_alu_mov); sb.push_back(v_wreg); end
            5'b101_00,
            5'b101_10: begin sb.push_back(v_geta); sb.push_back(v_getb); sb.push_back(v_alu_c); sb.push_back(v_wreg); end
            5'b101_01: begin sb.push_back(v_geta); sb.push_back(v_getb); sb.push_back(v_alu_s); end
            5'b101_11: begin sb.push_back(v_getb); sb.push_back(v_alu_c); sb.push_back(v_wreg); end
            default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                for (int i = 0; i < 12; i++) sb.push_back(v_halt);
`endif
            end
        endcase
`ifdef SEQ_ILLEGAL_TRAP_EN
        if (cls inside {5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11})
            sb.push_back(v_idle);
`else
        sb.push_back(v_idle);
`endif
    endtask

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%013b expected=%013b", tag, got, exp);
        end
    endtask

    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input bit hold_s,
                             input int change_at, input logic [2:0] new_opc, input string tag);
        int idx = 0;
        push_expected({opc, o});
        bus.opcode = opc;
        bus.op     = o;
        bus.s      = 1'b1;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            if (!hold_s) bus.s = 1'b0;
            chk($sformatf("%s[%0d]", tag, idx), obs(), sb.pop_front());
            if (idx == change_at) bus.opcode = new_opc;
            idx++;
        end
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_async"}, obs(), v_idle);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_released"}, obs(), v_idle);
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b0;
        bus.s      = 1'b0;
        bus.opcode = 3'b000;
        bus.op     = 2'b00;
        #12;
        chk("reset_state", obs(), v_idle);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_release", obs(), v_idle);

        run_instr(3'b110, 2'b10, 0, -1, 3'b000, "mov_imm");
        run_instr(3'b101, 2'b00, 0, -1, 3'b000, "add");
        run_instr(3'b101, 2'b01, 0, -1, 3'b000, "cmp");
        run_instr(3'b110, 2'b00, 0, -1, 3'b000, "mov_reg");
        run_instr(3'b101, 2'b11, 0, -1, 3'b000, "mvn");
        run_instr(3'b101, 2'b10, 0, -1, 3'b000, "and");

        // Opcode changes during GET_A must not disturb the latched ADD.
        run_instr(3'b101, 2'b00, 0, 1, 3'b110, "add_stable");

        // s held high: back-to-back starts with one WAIT cycle, pulses mid-instruction ignored.
        run_instr(3'b101, 2'b00, 1, -1, 3'b000, "b2b_add");
        run_instr(3'b110, 2'b10, 1, -1, 3'b000, "b2b_movimm");
        run_instr(3'b101, 2'b01, 0, -1, 3'b000, "b2b_cmp");

        // Reset during the ALU cycle of an AND.
        push_expected(5'b101_10);
        bus.opcode = 3'b101;
        bus.op     = 2'b10;
        bus.s      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.s = 1'b0;
            chk($sformatf("and_abort[%0d]", i), obs(), sb.pop_front());
        end
        sb.delete();
        reset = 1'b0;
        #1;
        chk("abort_async", obs(), v_idle);
        @(posedge clk); #1;
        chk("abort_held", obs(), v_idle);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_nowrite[%0d]", i), obs(), v_idle);
        end

        // Illegal classes.
        run_instr(3'b111, 2'b00, 0, -1, 3'b000, "illegal_111");
        pulse_reset("illegal_111_rst");
        run_instr(3'b110, 2'b01, 0, -1, 3'b000, "illegal_110_01");
        pulse_reset("illegal_110_01_rst");

        run_instr(3'b110, 2'b10, 0, -1, 3'b000, "mov_imm_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
